// File: rtl/ifu_pkg.sv
// Shared IFU types: fetch/half widths, aligner state encoding and the RVC length test.
package ifu_pkg;

  localparam int HALF_W  = 16;
  localparam int FETCH_W = 32;

  typedef enum logic [1:0] {
    ALIGN_NORM = 2'd0,
    ALIGN_HALF = 2'd1,
    ALIGN_SKIP = 2'd2
  } align_state_e;

  // 48/64-bit encodings are not supported, so anything not ending in 2'b11 is 16-bit.
  function automatic logic is_rvc(input logic [HALF_W-1:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ifu_inst_align.sv
// Fetch-word to instruction aligner: pops 32-bit FIFO words, reassembles RVC/32-bit
// instructions (including ones straddling two words) and hands one per cycle to decode.
module ifu_inst_align
  import ifu_pkg::*;
#(
  parameter int              PC_W   = 64,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  input  logic               fifo_empty,
  input  logic [FETCH_W-1:0] fifo_rdata,
  output logic               fifo_rready,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [FETCH_W-1:0] inst,
  output logic [PC_W-1:0]    inst_pc,
  output logic               inst_is_rvc
);

  align_state_e        state, state_nxt;
  logic [HALF_W-1:0]   res_half, res_nxt;
  logic [PC_W-1:0]     pc_r;

  logic                load, pop, emit, emit_rvc;
  logic [FETCH_W-1:0]  emit_inst;
  logic [2:0]          step;
  logic [HALF_W-1:0]   lo, hi;

  assign lo          = fifo_rdata[HALF_W-1:0];
  assign hi          = fifo_rdata[FETCH_W-1:HALF_W];
  assign fifo_rready = pop;

  always_comb begin
    load      = !inst_valid || inst_ready;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_rvc  = 1'b0;
    emit_inst = '0;
    step      = 3'd0;
    state_nxt = state;
    res_nxt   = res_half;
    if (!flush && load) begin
      case (state)
        ALIGN_NORM: begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            emit = 1'b1;
            if (is_rvc(lo)) begin
              emit_inst = {{HALF_W{1'b0}}, lo};
              emit_rvc  = 1'b1;
              res_nxt   = hi;
              step      = 3'd2;
              state_nxt = ALIGN_HALF;
            end else begin
              emit_inst = fifo_rdata;
              step      = 3'd4;
            end
          end
        end
        ALIGN_HALF: begin
          // A compressed residue needs no new word, so it drains even with the FIFO empty.
          if (is_rvc(res_half)) begin
            emit      = 1'b1;
            emit_inst = {{HALF_W{1'b0}}, res_half};
            emit_rvc  = 1'b1;
            step      = 3'd2;
            state_nxt = ALIGN_NORM;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            emit      = 1'b1;
            emit_inst = {lo, res_half};
            res_nxt   = hi;
            step      = 3'd4;
          end
        end
        ALIGN_SKIP: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            res_nxt   = hi;
            state_nxt = ALIGN_HALF;
          end
        end
        default: state_nxt = ALIGN_NORM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ALIGN_NORM;
      res_half    <= '0;
      pc_r        <= RST_PC;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      inst_is_rvc <= 1'b0;
    end else if (flush) begin
      inst_valid <= 1'b0;
      pc_r       <= flush_pc;
      state      <= flush_pc[1] ? ALIGN_SKIP : ALIGN_NORM;
      res_half   <= '0;
    end else if (load) begin
      state      <= state_nxt;
      res_half   <= res_nxt;
      pc_r       <= pc_r + {{(PC_W-3){1'b0}}, step};
      inst_valid <= emit;
      if (emit) begin
        inst        <= emit_inst;
        inst_pc     <= pc_r;
        inst_is_rvc <= emit_rvc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_inst_align.sv
// Self-checking bench for ifu_inst_align: directed scenarios plus random traffic against a
// halfword-stream reference model (instructions parsed from the pushed byte stream).
module tb_ifu_inst_align;

  localparam int          PC_W   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic            clk, rst_n, flush, fifo_empty, fifo_rready;
  logic [PC_W-1:0] flush_pc, inst_pc;
  logic [31:0]     fifo_rdata, inst;
  logic            inst_valid, inst_ready, inst_is_rvc;

  ifu_inst_align #(.PC_W(PC_W), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rready(fifo_rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_is_rvc(inst_is_rvc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errs = 0, checks = 0;
  logic [31:0] fq[$];
  logic [15:0] hq[$];
  logic [63:0] mpc;
  bit          mskip;
  int          acc_cnt = 0, pop_cnt = 0;
  logic [31:0] last_inst;
  logic [63:0] last_pc;
  bit          hold_prev;
  logic [31:0] hold_inst;
  logic [63:0] hold_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
  endtask

  // The instruction stream is just the pushed halves in address order.
  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    if (mskip) mskip = 1'b0; else hq.push_back(w[15:0]);
    hq.push_back(w[31:16]);
    drive();
  endtask

  task automatic model_reset(input logic [63:0] pc);
    fq.delete();
    hq.delete();
    mpc       = pc;
    mskip     = pc[1];
    hold_prev = 1'b0;
    drive();
  endtask

  task automatic cycle();
    logic        pop, fl;
    logic [63:0] fpc;
    logic [15:0] h0, h1;
    logic [31:0] einst;
    logic        erv;
    @(negedge clk);
    if (fifo_empty || flush) chk("rready_gate", fifo_rready, 1'b0);
    if (hold_prev) begin
      chk("hold_valid", inst_valid, 1'b1);
      chk("hold_inst", inst, hold_inst);
      chk("hold_pc", inst_pc, hold_pc);
    end
    if (inst_valid && inst_ready) begin
      if (hq.size() == 0) chk("model_underrun", hq.size(), 1);
      else begin
        h0  = hq.pop_front();
        erv = (h0[1:0] != 2'b11);
        if (erv) einst = {16'h0, h0};
        else if (hq.size() == 0) begin
          chk("model_underrun32", hq.size(), 1);
          einst = 32'hx;
        end else begin
          h1    = hq.pop_front();
          einst = {h1, h0};
        end
        chk("inst", inst, einst);
        chk("inst_pc", inst_pc, mpc);
        chk("inst_is_rvc", inst_is_rvc, erv);
        mpc       = mpc + (erv ? 64'd2 : 64'd4);
        acc_cnt++;
        last_inst = inst;
        last_pc   = inst_pc;
      end
    end
    hold_prev = inst_valid && !inst_ready && !flush;
    hold_inst = inst;
    hold_pc   = inst_pc;
    pop = fifo_rready;
    fl  = flush;
    fpc = flush_pc;
    @(posedge clk);
    #1;
    if (pop) begin
      pop_cnt++;
      void'(fq.pop_front());
    end
    if (fl) model_reset(fpc); else drive();
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; inst_ready = 1'b0;
    model_reset(RST_PC);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 64'h0);
    chk("rst_rvc", inst_is_rvc, 1'b0);
    chk("rst_rready", fifo_rready, 1'b0);
    rst_n = 1'b1;
    #1;

    // single 32-bit instruction
    inst_ready = 1'b1;
    push(32'h0000_0413);
    #1;
    chk("t1_rready", fifo_rready, 1'b1);
    cycle();
    chk("t1_valid", inst_valid, 1'b1);
    chk("t1_inst", inst, 32'h0000_0413);
    chk("t1_pc", inst_pc, 64'h8000_0000);
    chk("t1_rvc", inst_is_rvc, 1'b0);
    cycle();
    chk("t1_acc", acc_cnt, 1);
    chk("t1_pops", pop_cnt, 1);

    // two RVC in one word, one pop
    push(32'h0001_4501);
    repeat (3) cycle();
    chk("t2_acc", acc_cnt, 3);
    chk("t2_pops", pop_cnt, 2);
    chk("t2_last_inst", last_inst, 32'h0000_0001);
    chk("t2_last_pc", last_pc, 64'h8000_0006);

    // straddle with the FIFO running dry in the middle
    push(32'h0413_4501);
    repeat (2) cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_stall_valid", inst_valid, 1'b0);
      chk("t3_stall_rready", fifo_rready, 1'b0);
    end
    push(32'h0000_0000);
    cycle();
    chk("t3_inst", inst, 32'h0000_0413);
    chk("t3_pc", inst_pc, 64'h8000_000A);
    chk("t3_rvc", inst_is_rvc, 1'b0);
    repeat (2) cycle();

    // decode backpressure with a full FIFO
    for (int i = 0; i < 4; i++) push($urandom);
    inst_ready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_hold_rready", fifo_rready, 1'b0);
    end
    inst_ready = 1'b1;
    repeat (12) cycle();
    chk("t4_fifo_drained", fq.size(), 0);

    // misaligned redirect while a straddle is pending
    push(32'h0413_4501);
    repeat (2) cycle();
    flush = 1'b1; flush_pc = 64'h8000_0102;
    cycle();
    flush = 1'b0;
    push(32'h4505_1234);
    repeat (2) cycle();
    chk("t5_inst", inst, 32'h0000_4505);
    chk("t5_pc", inst_pc, 64'h8000_0102);
    chk("t5_rvc", inst_is_rvc, 1'b1);
    cycle();
    flush = 1'b1; flush_pc = 64'h8000_0100;
    cycle();
    flush = 1'b0;
    push(32'h0413_4509);
    cycle();
    chk("t6_inst", inst, 32'h0000_4509);
    chk("t6_pc", inst_pc, 64'h8000_0100);
    cycle();

    // random traffic, redirects including near the top of the address space
    for (int n = 0; n < 4000; n++) begin
      inst_ready = ($urandom % 10) < 7;
      flush      = ($urandom % 40) == 0;
      if (flush) begin
        if ($urandom % 4 == 0) flush_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'({$urandom} % 16);
        else flush_pc = {32'h0, $urandom};
        flush_pc[0] = 1'b0;
      end else if (fq.size() < 4 && ($urandom % 2 == 0)) begin
        push($urandom);
      end
      cycle();
    end
    flush = 1'b0;
    inst_ready = 1'b1;
    repeat (10) cycle();
    ok = (hq.size() == 0) || (hq.size() == 1 && hq[0][1:0] == 2'b11);
    chk("drain_residue", ok, 1'b1);

    // async reset while a straddle residue is held
    flush = 1'b1; flush_pc = 64'h8000_2000;
    cycle();
    flush = 1'b0;
    push(32'h0413_4501);
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    model_reset(RST_PC);
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_rready", fifo_rready, 1'b0);
    #1;
    rst_n = 1'b1;
    push(32'h0000_0413);
    cycle();
    chk("arst_inst", inst, 32'h0000_0413);
    chk("arst_pc", inst_pc, 64'h8000_0000);
    chk("arst_rvc", inst_is_rvc, 1'b0);
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
